resize_controller: RTL

RESIZE_CONTROLLER -- requirements
Module: resize_controller

---
 rtl/resize_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/resize_controller.sv
// resize_controller: frame downscaler that consumes a raster of {r,g,b}
// pixels and writes every S-th pixel of every S-th line (S = 1, 2 or 4)
// into an output buffer. It writes addresses in raster order of the
// reduced image.
// Optional feature macro: RESIZE_HAVG_EN. When it is defined, each written
// pixel is the horizontal box average of S source pixels on the selected
// line. When it is undefined, the design does plain decimation.
module resize_controller #(
   parameter int IMG_W = 768,
   parameter int IMG_H = 512
) (
   input  logic        horizontal_clock,
   input  logic        horizontal_reset,
   input  logic        start,
   input  logic [1:0]  scale_sel,
   input  logic        horizontal_sync,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic        wr_en,
   output logic [18:0] wr_addr,
   output logic [23:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      ACTIVE,
      DONE
   } state_t;

   state_t        state_reg;
   state_t        state_next;

   logic [CW-1:0] col_reg;
   logic [RW-1:0] row_reg;
   // Low-bit mask for the latched scale: 00 -> S=1, 01 -> S=2, 11 -> S=4.
   logic [1:0]    mask_reg;
   // The write address is a running count, because writes come out in
   // output raster order.
   logic [18:0]   addr_cnt_reg;

   logic          wr_en_reg;
   logic [18:0]   wr_addr_reg;
   logic [23:0]   wr_data_reg;
   logic          err_reg;

   logic          accept;
   logic          reject;
   logic          consume;

   logic          row_sel;
   logic          col_grp_first;
   logic          pixel_write;
   logic [23:0]   pixel_data;

   // The pixel position inside its S x S tile comes from the two low
   // counter bits. IMG_W and IMG_H are multiples of 4, so these bits exist.
   assign row_sel       = (row_reg[1:0] & mask_reg) == 2'b00;
   assign col_grp_first = (col_reg[1:0] & mask_reg) == 2'b00;

`ifdef RESIZE_HAVG_EN
   logic [23:0] pixel_in;
   logic [1:0]  shift_amt;
   logic [23:0] avg_data;
   logic        col_grp_last;

   assign pixel_in     = {r, g, b};
   // log2(S) recovered from the mask.
   assign shift_amt    = {mask_reg[1], mask_reg[0] & ~mask_reg[1]};
   assign col_grp_last = (col_reg[1:0] & mask_reg) == mask_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [9:0] sum_reg;
         logic [9:0] sum_next;

         // The first pixel of a group restarts the sum. The others add to it.
         assign sum_next = col_grp_first ? {2'b00, pixel_in[8*gi +: 8]}
                                         : sum_reg + {2'b00, pixel_in[8*gi +: 8]};
         assign avg_data[8*gi +: 8] = 8'(sum_next >> shift_amt);

         // Per-channel running sum, advanced only on consumed pixels of selected lines.
         always_ff @(posedge horizontal_clock) begin
            if (horizontal_reset) begin
               sum_reg <= '0;
            end else if (consume && row_sel) begin
               sum_reg <= sum_next;
            end
         end
      end
   endgenerate

   // The write is issued once the last pixel of a group has arrived.
   assign pixel_write = consume && row_sel && col_grp_last;
   assign pixel_data  = avg_data;
`else
   assign pixel_write = consume && row_sel && col_grp_first;
   assign pixel_data  = {r, g, b};
`endif

   // State register.
   always_ff @(posedge horizontal_clock) begin
      if (horizontal_reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic, plus decoding of start requests and pixel consumption.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      reject     = 1'b0;
      consume    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (scale_sel == 2'b11) begin
                  reject = 1'b1;
               end else begin
                  accept     = 1'b1;
                  state_next = ARMED;
               end
            end
         end
         ARMED, ACTIVE: begin
            if (horizontal_sync) begin
               consume    = 1'b1;
               state_next = ACTIVE;
               if (col_reg == COL_LAST && row_reg == ROW_LAST) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Raster counters, scale latch, and the one-cycle registered write port.
   always_ff @(posedge horizontal_clock) begin
      if (horizontal_reset) begin
         col_reg      <= '0;
         row_reg      <= '0;
         mask_reg     <= 2'b00;
         addr_cnt_reg <= '0;
         wr_en_reg    <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= '0;
         err_reg      <= 1'b0;
      end else begin
         wr_en_reg <= pixel_write;
         err_reg   <= reject;
         if (accept) begin
            col_reg      <= '0;
            row_reg      <= '0;
            addr_cnt_reg <= '0;
            case (scale_sel)
               2'b01:   mask_reg <= 2'b01;
               2'b10:   mask_reg <= 2'b11;
               default: mask_reg <= 2'b00;
            endcase
         end
         if (consume) begin
            if (col_reg == COL_LAST) begin
               col_reg <= '0;
               row_reg <= row_reg + 1'b1;
            end else begin
               col_reg <= col_reg + 1'b1;
            end
         end
         if (pixel_write) begin
            wr_addr_reg  <= addr_cnt_reg;
            wr_data_reg  <= pixel_data;
            addr_cnt_reg <= addr_cnt_reg + 19'd1;
         end
      end
   end

   assign wr_en   = wr_en_reg;
   assign wr_addr = wr_addr_reg;
   assign wr_data = wr_data_reg;
   assign err     = err_reg;
   assign busy    = (state_reg == ARMED) || (state_reg == ACTIVE);
   assign done    = (state_reg == DONE);

endmodule
